sram_port_arbiter: RTL and testbench

//  Shares one SRAM-like memory port (req/wr/size/addr/wdata -> rdata/addr_ok/data_ok) between the CPU

---
 rtl/sram_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one SRAM-like memory port between the CPU instruction master and
//   data master. A request is granted to one master. The grant stays with that
//   master until the slave accepts it. Every accepted transaction pushes its
//   owner ID into an in-order tag FIFO. Each slave response pops the FIFO head,
//   and the response goes to the master that owns that head entry.
//
//   Configuration macro:
//     ARB_ROUND_ROBIN_EN  defined   -> on a tie, grant the master that did not
//                                      win the last accept (DATA wins the first
//                                      tie after reset)
//                         undefined -> fixed priority, DATA wins every tie
//
//   Ports
//     clk, rst                   clock, synchronous active-high reset
//     inst_* / data_*            master request side (req/wr/size/addr/wdata in;
//                                rdata/addr_ok/data_ok out)
//     mem_req/wr/size/addr/wdata slave request, payload of the granted master
//     mem_rdata/addr_ok/data_ok  slave accept and in-order response
//     outstanding                current tag-FIFO occupancy
//     err_unexpected             sticky: response arrived with empty FIFO
// ----------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction master
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  // data master
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  // memory slave
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  // status
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic        err_unexpected
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            tag_q [MAX_OUTSTANDING];
  logic            err_q, err_d;

  logic            grant_vld;
  logic            grant_own;
  logic            tie_own;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            unexpected;
  logic            head_own;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == {CW{1'b0}});
  assign head_own   = tag_q[head_q];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Tie goes to the master that did not win the most recent accept.
  assign tie_own = ~last_q;

  // Remember the owner of every accepted request.
  always_comb begin
    if (push) begin
      last_d = grant_own;
    end else begin
      last_d = last_q;
    end
  end

  // Last-granted register; starts at INST so the first tie goes to DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_INST;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: data master always wins a tie.
  assign tie_own = OWN_DATA;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: lock onto the winner until the slave accepts it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld && !mem_addr_ok) begin
          state_d = (grant_own == OWN_DATA) ? ST_LOCK_DATA : ST_LOCK_INST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK_INST: begin
        if (grant_vld && mem_addr_ok) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCK_INST;
        end
      end
      ST_LOCK_DATA: begin
        if (grant_vld && mem_addr_ok) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOCK_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: grant selection and the muxed slave payload.
  // A full FIFO blocks new grants even when a response pops in the same cycle.
  // In a lock state mem_req follows the owner's req, even if the owner drops it.
  always_comb begin
    grant_vld = 1'b0;
    grant_own = OWN_INST;
    if (rst) begin
      grant_vld = 1'b0;
      grant_own = OWN_INST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fifo_full) begin
            grant_vld = 1'b0;
            grant_own = OWN_INST;
          end else if (inst_req && data_req) begin
            grant_vld = 1'b1;
            grant_own = tie_own;
          end else if (data_req) begin
            grant_vld = 1'b1;
            grant_own = OWN_DATA;
          end else if (inst_req) begin
            grant_vld = 1'b1;
            grant_own = OWN_INST;
          end else begin
            grant_vld = 1'b0;
            grant_own = OWN_INST;
          end
        end
        ST_LOCK_INST: begin
          grant_vld = inst_req;
          grant_own = OWN_INST;
        end
        ST_LOCK_DATA: begin
          grant_vld = data_req;
          grant_own = OWN_DATA;
        end
        default: begin
          grant_vld = 1'b0;
          grant_own = OWN_INST;
        end
      endcase
    end

    mem_req = grant_vld;
    if (!grant_vld) begin
      mem_wr    = 1'b0;
      mem_size  = 2'd0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
    end else if (grant_own == OWN_DATA) begin
      mem_wr    = data_wr;
      mem_size  = data_size;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end else begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  // Accept / response strobes; slave activity during reset is ignored.
  assign push       = grant_vld & mem_addr_ok;
  assign pop        = mem_data_ok & ~rst & ~fifo_empty;
  assign unexpected = mem_data_ok & ~rst & fifo_empty;

  // Route accepts and responses to their owner; the other master stays silent.
  always_comb begin
    inst_addr_ok = push & (grant_own == OWN_INST);
    data_addr_ok = push & (grant_own == OWN_DATA);
    inst_data_ok = pop & (head_own == OWN_INST);
    data_data_ok = pop & (head_own == OWN_DATA);
    if (inst_data_ok) begin
      inst_rdata = mem_rdata;
    end else begin
      inst_rdata = 32'd0;
    end
    if (data_data_ok) begin
      data_rdata = mem_rdata;
    end else begin
      data_rdata = 32'd0;
    end
  end

  // Tag FIFO pointer/count and sticky error next state.
  // Pointers wrap naturally because MAX_OUTSTANDING is a power of two.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;
    if (push) begin
      tail_d = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (unexpected) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Tag FIFO state and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Tag storage: owner ID written at the tail on each accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_q[i] <= OWN_INST;
      end
    end else if (push) begin
      tag_q[tail_q] <= grant_own;
    end
  end

  // Status outputs read as zero while reset is held.
  assign outstanding    = rst ? {CW{1'b0}} : count_q;
  assign err_unexpected = err_q & ~rst;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter (MAX_OUTSTANDING = 4).
// Inputs change 1 time unit after the rising edge. Outputs are checked on the
// falling edge.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  outstanding;
  logic        err_unexpected;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_own [4];

  sram_port_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .outstanding(outstanding), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2;
    inst_addr = 32'd0; inst_wdata = 32'd0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2;
    data_addr = 32'd0; data_wdata = 32'd0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    // Reset: activity on every input must not reach any output.
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    mid();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
    chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);
    chk("rst_err", 32'(err_unexpected), 32'd0);
    nxt();
    nxt();
    rst = 1'b0;
    clear_inputs();
    mid();
    chk("post_rst_outstanding", 32'(outstanding), 32'd0);
    nxt();

    // T1: single inst read, accepted now, answered next cycle.
    inst_req = 1'b1; inst_addr = 32'h40; mem_addr_ok = 1'b1;
    mid();
    chk("t1_mem_req", 32'(mem_req), 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h40);
    chk("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("t1_data_addr_ok", 32'(data_addr_ok), 32'd0);
    nxt();
    clear_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'h1234;
    mid();
    chk("t1_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("t1_inst_rdata", inst_rdata, 32'h1234);
    chk("t1_data_data_ok", 32'(data_data_ok), 32'd0);
    chk("t1_data_rdata", data_rdata, 32'd0);
    chk("t1_outstanding", 32'(outstanding), 32'd1);
    nxt();
    clear_inputs();
    mid();
    chk("t1_drained", 32'(outstanding), 32'd0);
    nxt();

    // T2: both masters request every cycle; each cycle also answers the previous accept.
`ifdef ARB_ROUND_ROBIN_EN
    exp_own[0] = 1'b1; exp_own[1] = 1'b0; exp_own[2] = 1'b1; exp_own[3] = 1'b0;
`else
    exp_own[0] = 1'b1; exp_own[1] = 1'b1; exp_own[2] = 1'b1; exp_own[3] = 1'b1;
`endif
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      inst_addr = 32'h100; data_addr = 32'h200;
      if (c < 4) begin
        inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
      end
      if (c >= 1) begin
        mem_data_ok = 1'b1; mem_rdata = 32'hA000 + 32'(c);
      end
      mid();
      if (c < 4) begin
        chk($sformatf("t2_mem_addr_%0d", c), mem_addr, exp_own[c] ? 32'h200 : 32'h100);
        chk($sformatf("t2_data_addr_ok_%0d", c), 32'(data_addr_ok), 32'(exp_own[c]));
        chk($sformatf("t2_inst_addr_ok_%0d", c), 32'(inst_addr_ok), 32'(!exp_own[c]));
      end
      if (c >= 1) begin
        chk($sformatf("t2_data_data_ok_%0d", c), 32'(data_data_ok), 32'(exp_own[c-1]));
        chk($sformatf("t2_inst_data_ok_%0d", c), 32'(inst_data_ok), 32'(!exp_own[c-1]));
        chk($sformatf("t2_rdata_%0d", c), exp_own[c-1] ? data_rdata : inst_rdata,
            32'hA000 + 32'(c));
      end
      nxt();
    end
    clear_inputs();
    mid();
    chk("t2_drained", 32'(outstanding), 32'd0);
    nxt();

    // T3: slave stalls inst for 3 cycles; data must wait for the lock to release.
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      inst_addr = 32'h300; data_addr = 32'h400;
      inst_req = (c <= 3);
      data_req = (c >= 1);
      mem_addr_ok = (c >= 3);
      mid();
      if (c <= 3) begin
        chk($sformatf("t3_mem_addr_%0d", c), mem_addr, 32'h300);
        chk($sformatf("t3_inst_addr_ok_%0d", c), 32'(inst_addr_ok), (c == 3) ? 32'd1 : 32'd0);
        chk($sformatf("t3_data_addr_ok_%0d", c), 32'(data_addr_ok), 32'd0);
      end else begin
        chk("t3_mem_addr_data", mem_addr, 32'h400);
        chk("t3_data_addr_ok", 32'(data_addr_ok), 32'd1);
      end
      nxt();
    end
    // Responses come back in accept order: inst first, then data.
    clear_inputs();
    mem_data_ok = 1'b1; mem_rdata = 32'h3333;
    mid();
    chk("t3_resp0_inst", 32'(inst_data_ok), 32'd1);
    chk("t3_resp0_data", 32'(data_data_ok), 32'd0);
    nxt();
    mem_rdata = 32'h4444;
    mid();
    chk("t3_resp1_data", 32'(data_data_ok), 32'd1);
    chk("t3_resp1_rdata", data_rdata, 32'h4444);
    chk("t3_resp1_inst", 32'(inst_data_ok), 32'd0);
    nxt();

    // T4: slave never answers; the FIFO fills at 4 and blocks further grants.
    clear_inputs();
    inst_req = 1'b1; inst_addr = 32'h500; mem_addr_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      mid();
      chk($sformatf("t4_addr_ok_%0d", c), 32'(inst_addr_ok), 32'd1);
      nxt();
    end
    mid();
    chk("t4_full_outstanding", 32'(outstanding), 32'd4);
    chk("t4_full_mem_req", 32'(mem_req), 32'd0);
    chk("t4_full_addr_ok", 32'(inst_addr_ok), 32'd0);
    nxt();
    mem_data_ok = 1'b1; mem_rdata = 32'h5555;
    mid();
    chk("t4_pop_data_ok", 32'(inst_data_ok), 32'd1);
    chk("t4_pop_blocks_push", 32'(mem_req), 32'd0);
    nxt();
    mem_data_ok = 1'b0;
    mid();
    chk("t4_after_pop_outstanding", 32'(outstanding), 32'd3);
    chk("t4_fifth_addr_ok", 32'(inst_addr_ok), 32'd1);
    nxt();
    mid();
    chk("t4_refull_mem_req", 32'(mem_req), 32'd0);
    nxt();
    clear_inputs();
    for (int c = 0; c < 4; c++) begin
      mem_data_ok = 1'b1;
      mid();
      chk($sformatf("t4_drain_cnt_%0d", c), 32'(outstanding), 32'(4 - c));
      chk($sformatf("t4_drain_ok_%0d", c), 32'(inst_data_ok), 32'd1);
      nxt();
    end
    clear_inputs();
    mid();
    chk("t4_drained", 32'(outstanding), 32'd0);
    nxt();

    // T5: response with empty FIFO is dropped and sets the sticky error.
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD;
    mid();
    chk("t5_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("t5_data_data_ok", 32'(data_data_ok), 32'd0);
    chk("t5_err_before", 32'(err_unexpected), 32'd0);
    nxt();
    clear_inputs();
    mid();
    chk("t5_err_set", 32'(err_unexpected), 32'd1);
    nxt();
    mid();
    chk("t5_err_sticky", 32'(err_unexpected), 32'd1);
    nxt();

    // T6: reset with 3 outstanding; a late response then counts as unexpected.
    inst_req = 1'b1; inst_addr = 32'h600; mem_addr_ok = 1'b1;
    nxt(); nxt(); nxt();
    clear_inputs();
    mid();
    chk("t6_outstanding", 32'(outstanding), 32'd3);
    nxt();
    rst = 1'b1;
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    mid();
    chk("t6_rst_outstanding", 32'(outstanding), 32'd0);
    chk("t6_rst_mem_req", 32'(mem_req), 32'd0);
    chk("t6_rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("t6_rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("t6_rst_err", 32'(err_unexpected), 32'd0);
    nxt();
    rst = 1'b0;
    clear_inputs();
    mid();
    chk("t6_post_outstanding", 32'(outstanding), 32'd0);
    chk("t6_post_err", 32'(err_unexpected), 32'd0);
    nxt();
    mem_data_ok = 1'b1;
    mid();
    chk("t6_late_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("t6_late_data_data_ok", 32'(data_data_ok), 32'd0);
    nxt();
    clear_inputs();
    mid();
    chk("t6_late_err", 32'(err_unexpected), 32'd1);
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
